alu_result_capture: RTL and testbench

- Registered consumer for the ALU's combinational outputs.
- Latches each valid result with its destination tag into a 2-entry skid buffer and drives the writeback stage over a valid/ready handshake.
- Maintains the architectural NZCV status register.
- Evaluates 4-bit condition codes against the status register for branch/predication logic.

---
 rtl/alu_result_capture.sv | 122 ++++++++++++
 tb/tb_alu_result_capture.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_capture.sv
// Registered capture stage for ALU results: 2-entry skid FIFO toward writeback,
// architectural NZCV register and condition-code evaluation on the registered flags.
module alu_result_capture #(
  parameter int DATA_W = 40,
  parameter int TAG_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] dataInResult,
  input  logic              controlInAluZ,
  input  logic              controlInAluC,
  input  logic              controlInAluV,
  input  logic              controlInAluN,
  input  logic              controlInValid,
  input  logic              controlInFlagWrite,
  input  logic [TAG_W-1:0]  controlInDest,
  input  logic              controlInFlush,
  input  logic [3:0]        controlInCond,
  input  logic              controlInWbReady,
  output logic              controlOutStall,
  output logic [DATA_W-1:0] dataOutResult,
  output logic [TAG_W-1:0]  dataOutDest,
  output logic              controlOutValid,
  output logic [3:0]        dataOutFlags,
  output logic              controlOutCondTrue
);

  logic [DATA_W-1:0] res_q  [2];
  logic [DATA_W-1:0] res_d  [2];
  logic [TAG_W-1:0]  dest_q [2];
  logic [TAG_W-1:0]  dest_d [2];
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic [1:0]        count_q, count_d;
  logic [3:0]        flags_q, flags_d;
  logic              push, pop;

  // Flags are packed {N,Z,C,V}.
  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cond)
      4'd0:    cond_eval = z;
      4'd1:    cond_eval = ~z;
      4'd2:    cond_eval = c;
      4'd3:    cond_eval = ~c;
      4'd4:    cond_eval = n;
      4'd5:    cond_eval = ~n;
      4'd6:    cond_eval = v;
      4'd7:    cond_eval = ~v;
      4'd8:    cond_eval = c & ~z;
      4'd9:    cond_eval = ~c | z;
      4'd10:   cond_eval = (n == v);
      4'd11:   cond_eval = (n != v);
      4'd12:   cond_eval = ~z & (n == v);
      4'd13:   cond_eval = z | (n != v);
      4'd14:   cond_eval = 1'b1;
      default: cond_eval = 1'b0;
    endcase
  endfunction

  assign controlOutValid    = (count_q != 2'd0);
  assign controlOutStall    = (count_q == 2'd2);
  assign dataOutResult      = res_q[rd_ptr_q];
  assign dataOutDest        = dest_q[rd_ptr_q];
  assign dataOutFlags       = flags_q;
  assign controlOutCondTrue = cond_eval(controlInCond, flags_q);

  assign push = controlInValid & ~controlOutStall;
  assign pop  = controlOutValid & controlInWbReady;

  always_comb begin
    res_d    = res_q;
    dest_d   = dest_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    flags_d  = flags_q;
    // Flush wins over everything, including the flag write of a same-cycle push.
    if (controlInFlush) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push) begin
        res_d[wr_ptr_q]  = dataInResult;
        dest_d[wr_ptr_q] = controlInDest;
        wr_ptr_d         = ~wr_ptr_q;
        if (controlInFlagWrite)
          flags_d = {controlInAluN, controlInAluZ, controlInAluC, controlInAluV};
      end
      if (pop)
        rd_ptr_d = ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        res_q[i]  <= '0;
        dest_q[i] <= '0;
      end
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      flags_q  <= 4'b0000;
    end else begin
      res_q    <= res_d;
      dest_q   <= dest_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      flags_q  <= flags_d;
    end
  end

endmodule

// File: tb/tb_alu_result_capture.sv
// Bench for alu_result_capture: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_alu_result_capture;
  localparam int DATA_W = 40;
  localparam int TAG_W  = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DATA_W-1:0] dataInResult = '0;
  logic              controlInAluZ = 1'b0, controlInAluC = 1'b0;
  logic              controlInAluV = 1'b0, controlInAluN = 1'b0;
  logic              controlInValid = 1'b0, controlInFlagWrite = 1'b0;
  logic [TAG_W-1:0]  controlInDest = '0;
  logic              controlInFlush = 1'b0;
  logic [3:0]        controlInCond = 4'd14;
  logic              controlInWbReady = 1'b0;
  logic              controlOutStall, controlOutValid, controlOutCondTrue;
  logic [DATA_W-1:0] dataOutResult;
  logic [TAG_W-1:0]  dataOutDest;
  logic [3:0]        dataOutFlags;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [DATA_W-1:0] res;
    logic [TAG_W-1:0]  dest;
  } entry_t;
  entry_t     mq[$];
  logic [3:0] mflags = 4'b0000;

  alu_result_capture #(.DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .dataInResult(dataInResult),
    .controlInAluZ(controlInAluZ), .controlInAluC(controlInAluC),
    .controlInAluV(controlInAluV), .controlInAluN(controlInAluN),
    .controlInValid(controlInValid), .controlInFlagWrite(controlInFlagWrite),
    .controlInDest(controlInDest), .controlInFlush(controlInFlush),
    .controlInCond(controlInCond), .controlInWbReady(controlInWbReady),
    .controlOutStall(controlOutStall), .dataOutResult(dataOutResult),
    .dataOutDest(dataOutDest), .controlOutValid(controlOutValid),
    .dataOutFlags(dataOutFlags), .controlOutCondTrue(controlOutCondTrue)
  );

  always #5 clk = ~clk;

  // Pairs of conditions share a base test; the odd code of each pair is its inverse.
  function automatic logic mcond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, b;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: b = z;
      3'd1: b = cy;
      3'd2: b = n;
      3'd3: b = v;
      3'd4: b = cy && !z;
      3'd5: b = (n == v);
      3'd6: b = !z && (n == v);
      default: b = 1'b1;
    endcase
    return b ^ c[0];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO of at most two entries plus the flag register.
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete();
        mflags = 4'b0000;
      end else begin
        bit acc, rel;
        acc = controlInValid && (mq.size() < 2);
        rel = (mq.size() != 0) && controlInWbReady;
        if (controlInFlush) begin
          mq.delete();
        end else begin
          if (rel) void'(mq.pop_front());
          if (acc) begin
            entry_t e;
            e.res = dataInResult;
            e.dest = controlInDest;
            mq.push_back(e);
            if (controlInFlagWrite)
              mflags = {controlInAluN, controlInAluZ, controlInAluC, controlInAluV};
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("valid", controlOutValid, mq.size() != 0);
      chk("stall", controlOutStall, mq.size() == 2);
      chk("flags", dataOutFlags, mflags);
      chk("cond", controlOutCondTrue, mcond(controlInCond, mflags));
      if (mq.size() != 0) begin
        chk("result", dataOutResult, mq[0].res);
        chk("dest", dataOutDest, mq[0].dest);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_in(input logic [DATA_W-1:0] d, input logic [TAG_W-1:0] t,
                         input logic [3:0] nzcv, input logic fw);
    controlInValid = 1'b1;
    dataInResult = d;
    controlInDest = t;
    {controlInAluN, controlInAluZ, controlInAluC, controlInAluV} = nzcv;
    controlInFlagWrite = fw;
  endtask

  task automatic idle();
    controlInValid = 1'b0;
    controlInFlagWrite = 1'b0;
  endtask

  initial begin
    // Reset and idle
    step(); step();
    rst_n = 1'b1;
    step();
    chk("rst_valid", controlOutValid, 0);
    chk("rst_stall", controlOutStall, 0);
    chk("rst_flags", dataOutFlags, 4'b0000);
    chk("rst_result", dataOutResult, 0);
    controlInCond = 4'd14; #1 chk("cond_al", controlOutCondTrue, 1);
    controlInCond = 4'd15; #1 chk("cond_nv", controlOutCondTrue, 0);

    // Single pass-through
    controlInWbReady = 1'b1;
    push_in(40'h00_0000_0005, 5'd3, 4'b0010, 1'b1);
    step();
    chk("pt_result", dataOutResult, 40'h5);
    chk("pt_dest", dataOutDest, 3);
    chk("pt_valid", controlOutValid, 1);
    chk("pt_flags", dataOutFlags, 4'b0010);
    controlInCond = 4'd2; #1 chk("cond_cs", controlOutCondTrue, 1);
    controlInCond = 4'd8; #1 chk("cond_hi", controlOutCondTrue, 1);
    idle(); step();
    chk("pt_drain", controlOutValid, 0);

    // Backpressure
    controlInWbReady = 1'b0;
    push_in(40'd1, 5'd1, 4'b0000, 1'b0); step();
    push_in(40'd2, 5'd2, 4'b0000, 1'b0); step();
    chk("bp_stall", controlOutStall, 1);
    push_in(40'd3, 5'd3, 4'b0000, 1'b0); step();
    chk("bp_hold_stall", controlOutStall, 1);
    chk("bp_head1", dataOutResult, 40'd1);
    controlInWbReady = 1'b1; step();
    chk("bp_head2", dataOutResult, 40'd2);
    chk("bp_unstall", controlOutStall, 0);
    step();
    chk("bp_head3", dataOutResult, 40'd3);
    idle(); step();
    chk("bp_empty", controlOutValid, 0);

    // Streaming at count 1
    for (int i = 10; i <= 12; i++) begin
      push_in(DATA_W'(i), TAG_W'(i), 4'b0000, 1'b0); step();
      chk("st_head", dataOutResult, i);
      chk("st_nostall", controlOutStall, 0);
    end
    idle(); step();

    // Flag gating
    push_in(40'hFF_FFFF_FFFF, 5'd7, 4'b1000, 1'b0); step();
    chk("fg_nowrite", dataOutFlags, 4'b0010);
    push_in(40'h0, 5'd8, 4'b0100, 1'b1); step();
    chk("fg_write", dataOutFlags, 4'b0100);
    controlInCond = 4'd0; #1 chk("cond_eq", controlOutCondTrue, 1);
    controlInCond = 4'd1; #1 chk("cond_ne", controlOutCondTrue, 0);
    idle(); step();

    // Flush with full buffer, then with a live push
    controlInWbReady = 1'b0;
    push_in(40'hA, 5'd10, 4'b0000, 1'b0); step();
    push_in(40'hB, 5'd11, 4'b0000, 1'b0); step();
    push_in(40'hC, 5'd12, 4'b1001, 1'b1); controlInFlush = 1'b1; step();
    chk("fl_valid", controlOutValid, 0);
    chk("fl_stall", controlOutStall, 0);
    chk("fl_flags", dataOutFlags, 4'b0100);
    controlInFlush = 1'b0;
    push_in(40'hD, 5'd13, 4'b0000, 1'b0); step();
    push_in(40'hE, 5'd14, 4'b1111, 1'b1); controlInFlush = 1'b1; step();
    chk("fl2_valid", controlOutValid, 0);
    chk("fl2_flags", dataOutFlags, 4'b0100);
    controlInFlush = 1'b0;

    // Asynchronous reset mid-cycle
    push_in(40'hF, 5'd15, 4'b1010, 1'b1); step();
    push_in(40'h10, 5'd16, 4'b0000, 1'b0); step();
    idle();
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", controlOutValid, 0);
    chk("ar_stall", controlOutStall, 0);
    chk("ar_result", dataOutResult, 0);
    chk("ar_dest", dataOutDest, 0);
    chk("ar_flags", dataOutFlags, 4'b0000);
    step();
    rst_n = 1'b1;
    step();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [63:0] r;
      r = {$urandom, $urandom};
      controlInValid = ($urandom_range(0, 3) != 0);
      dataInResult = r[DATA_W-1:0];
      controlInDest = TAG_W'($urandom);
      {controlInAluN, controlInAluZ, controlInAluC, controlInAluV} = 4'($urandom);
      controlInFlagWrite = $urandom_range(0, 1);
      controlInFlush = ($urandom_range(0, 31) == 0);
      controlInWbReady = ($urandom_range(0, 2) != 0);
      controlInCond = 4'($urandom);
      step();
    end
    idle();
    controlInFlush = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
